// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 block: register numbers, exception codes and
// SR/Cause bit positions.
package cp0_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    // ERET travels down the pipeline as a pseudo-exception with an unused ExcCode.
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_ERET = 5'd31;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 8;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_TI     = 30;
    localparam int CAUSE_BD     = 31;

    function automatic logic isAddrError(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_irq_sync.sv
// Two-flop synchroniser for the asynchronous hardware interrupt lines.
module cp0_irq_sync #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] irqAsync,
    output logic [WIDTH-1:0] irqSync
);

    logic [WIDTH-1:0] stage1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage1  <= '0;
            irqSync <= '0;
        end else begin
            stage1  <= irqAsync;
            irqSync <= stage1;
        end
    end

endmodule

// File: rtl/cp0_v2.sv
// MIPS CP0: SR/Cause/EPC/BadVAddr/PrId with exception entry, ERET and interrupts.
// Define CP0_TIMER_EN to build the Count/Compare timer (TI ORs into IP[7]).
module cp0_v2
    import cp0_pkg::*;
#(
    parameter int          NUM_HW_IRQ     = 6,
    parameter logic [31:0] EXC_VECTOR     = 32'hBFC00380,
    parameter logic [31:0] PRID_VALUE     = 32'hDEADBEEF,
    parameter int          COUNT_DIV_LOG2 = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  writeEnable,
    input  logic [4:0]            number,
    input  logic [31:0]           writeData,
    output logic [31:0]           readData,
    input  logic                  hasExceptionInPipeline,
    input  logic                  isException,
    input  logic                  isBD,
    input  logic [4:0]            exceptionCause,
    input  logic [31:0]           exceptionPC,
    input  logic [31:0]           exceptionBadVAddr,
    output logic                  jump,
    output logic [31:0]           jumpAddress,
    output logic                  interruptNow,
    input  logic [NUM_HW_IRQ-1:0] externalInterrupt
);

    logic [7:0]            im;
    logic                  exl;
    logic                  ie;
    logic                  bd;
    logic [1:0]            swIp;
    logic [4:0]            excCode;
    logic [31:0]           epc;
    logic [31:0]           badVAddr;
    logic [7:0]            ip;
    logic [NUM_HW_IRQ-1:0] irqSync;
    logic                  ti;

    cp0_irq_sync #(.WIDTH(NUM_HW_IRQ)) uIrqSync (
        .clk      (clk),
        .reset    (reset),
        .irqAsync (externalInterrupt),
        .irqSync  (irqSync)
    );

    // Any reported exception or ERET takes precedence over a same-cycle mtc0.
    logic isEret;
    logic takeExc;
    logic swWrite;
    assign isEret  = exceptionCause == EXC_ERET;
    assign takeExc = isException && !isEret && !exl;
    assign swWrite = writeEnable && !isException;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im       <= 8'hFF;
            exl      <= 1'b1;
            ie       <= 1'b0;
            bd       <= 1'b0;
            swIp     <= 2'b00;
            excCode  <= 5'd0;
            epc      <= 32'd0;
            badVAddr <= 32'd0;
        end else if (takeExc) begin
            epc     <= isBD ? exceptionPC - 32'd4 : exceptionPC;
            bd      <= isBD;
            excCode <= exceptionCause;
            exl     <= 1'b1;
            if (isAddrError(exceptionCause)) begin
                badVAddr <= exceptionBadVAddr;
            end
        end else if (isException && isEret) begin
            exl <= 1'b0;
        end else if (swWrite) begin
            case (number)
                REG_SR: begin
                    im  <= writeData[SR_IM_LO +: 8];
                    exl <= writeData[SR_EXL];
                    ie  <= writeData[SR_IE];
                end
                REG_CAUSE: swIp <= writeData[CAUSE_IP_LO +: 2];
                REG_EPC:   epc  <= writeData;
                default: ;
            endcase
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        countTick;

    generate
        if (COUNT_DIV_LOG2 == 0) begin : gNoDiv
            assign countTick = 1'b1;
        end else begin : gDiv
            logic [COUNT_DIV_LOG2-1:0] div;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) div <= '0;
                else        div <= div + 1'b1;
            end
            assign countTick = &div;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= 32'd0;
            compare <= 32'd0;
            ti      <= 1'b0;
        end else begin
            if (swWrite && number == REG_COUNT) begin
                count <= writeData;
            end else if (countTick) begin
                count <= count + 32'd1;
            end
            if (swWrite && number == REG_COMPARE) begin
                compare <= writeData;
                ti      <= 1'b0;
            end else if (countTick && count == compare) begin
                ti <= 1'b1;
            end
        end
    end
`else
    assign ti = 1'b0;
`endif

    always_comb begin
        ip       = 8'd0;
        ip[1:0]  = swIp;
        ip[2 +: NUM_HW_IRQ] = irqSync;
        ip[7]    = ip[7] | ti;
    end

    always_comb begin
        readData = 32'd0;
        case (number)
            REG_BADVADDR: readData = badVAddr;
            REG_SR:       readData = {16'd0, im, 6'd0, exl, ie};
            REG_CAUSE:    readData = {bd, ti, 14'd0, ip, 1'b0, excCode, 2'b00};
            REG_EPC:      readData = epc;
            REG_PRID:     readData = PRID_VALUE;
`ifdef CP0_TIMER_EN
            REG_COUNT:    readData = count;
            REG_COMPARE:  readData = compare;
`endif
            default:      readData = 32'd0;
        endcase
    end

    assign jump         = isException;
    assign jumpAddress  = !isException ? 32'd0 : (isEret ? epc : EXC_VECTOR);
    assign interruptNow = ie && !exl && !hasExceptionInPipeline && |(ip & im);

endmodule
